block_memory: RTL

- Main-memory model behind the direct-mapped data cache. It serves block refills on a cache miss.
- Accepts a block-read request and waits a fixed, parameterised latency. It then returns a whole cache block (BLOCK_WORDS words) in one transfer.
- Holds a completed-read counter that the miss/hit statistics use.
- Sits directly downstream of the cache's miss path and is the only source of refill data.

---
 rtl/cache_pkg.sv | 15 +
 rtl/latency_counter.sv | 26 ++
 rtl/block_memory.sv | 95 +++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Constants and FSM state type shared by the data cache and its main-memory model.
package cache_pkg;

   localparam int unsigned WORD        = 32;
   localparam int unsigned ADDRESSL    = 15;
   localparam int unsigned BLOCK_BITS  = 2;
   localparam int unsigned BLOCK_WORDS = 1 << BLOCK_BITS;
   localparam int unsigned BADDR_W     = ADDRESSL - BLOCK_BITS;

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module latency_counter #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_dec && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/block_memory.sv
// Main-memory model serving whole-block refills after a fixed latency.
// Contents are address-as-data and never written, so storage is a ROM lookup.
module block_memory #(
   parameter int unsigned WORD       = cache_pkg::WORD,
   parameter int unsigned ADDRESSL   = cache_pkg::ADDRESSL,
   parameter int unsigned BLOCK_BITS = cache_pkg::BLOCK_BITS,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned CNTW       = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             read_req,
   input  logic [ADDRESSL-BLOCK_BITS-1:0]   block_addr,
   output logic [WORD*(2**BLOCK_BITS)-1:0]  block_data,
   output logic                             data_valid,
   output logic                             busy,
   output logic [CNTW-1:0]                  read_count
);
   import cache_pkg::*;

   localparam int unsigned NWORDS = 2 ** BLOCK_BITS;

   state_t                          r_state, w_next;
   logic [ADDRESSL-BLOCK_BITS-1:0]  r_addr;
   logic [WORD*NWORDS-1:0]          r_data, w_block;
   logic                            r_valid, r_busy;
   logic [CNTW-1:0]                 r_count;
   logic                            w_zero, w_accept, w_complete;

   function automatic logic [WORD-1:0] mem_word(input logic [ADDRESSL-1:0] a);
      return WORD'(a);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (read_req) w_next = WAIT;
         WAIT:    if (w_zero)   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_accept   = (r_state == IDLE) && read_req;
      w_complete = (r_state == WAIT) && w_zero;
   end

   latency_counter #(.W(8)) u_lat (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_load     (w_accept),
      .i_load_val (8'(LATENCY - 1)),
      .i_dec      (r_state == WAIT),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_block = '0;
      for (int unsigned k = 0; k < NWORDS; k++)
         w_block[WORD*k +: WORD] = mem_word({r_addr, BLOCK_BITS'(k)});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         r_valid <= w_complete;
         if (w_accept) begin
            r_addr <= block_addr;
            r_busy <= 1'b1;
         end else if (w_complete) begin
            r_busy <= 1'b0;
         end
         if (w_complete) begin
            r_data <= w_block;
            if (r_count != '1) r_count <= r_count + 1'b1;
         end
      end
   end

   assign block_data = r_data;
   assign data_valid = r_valid;
   assign busy       = r_busy;
   assign read_count = r_count;

endmodule
